demux_rr_dispatch: RTL and testbench

DEMUX_RR_DISPATCH -- requirements
Module: demux_rr_dispatch

---
 rtl/demux_rr_dispatch.sv | 92 +++++++++
 tb/tb_demux_rr_dispatch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_dispatch.sv
// One-beat buffered 1-to-4 demux that hands beats to channels in round-robin order.
// Build option DEMUX_SKIP_BUSY_EN: at accept, skip channels whose out_ready is low.
module demux_rr_dispatch #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic [1:0]    dst
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [1:0]      dst_q;
  logic [DW-1:0]   data_q;

  logic            hold;
  logic            take;
  logic            accept;
  logic [1:0]      base_ptr;
  logic [1:0]      sel_ch;

  assign hold     = (state_q == StHold);
  assign take     = hold & out_ready[dst_q];
  // Gated by rst_n so the block never advertises space while held in reset.
  assign in_ready = rst_n & ~flush & (~hold | out_ready[dst_q]);
  assign accept   = in_valid & in_ready;
  // On a same-cycle dispatch the new beat is routed from the already advanced pointer.
  assign base_ptr = take ? (dst_q + 2'd1) : ptr_q;

`ifdef DEMUX_SKIP_BUSY_EN
  logic [1:0] cand;

  // Descending scan so the closest ready channel after base_ptr wins.
  always_comb begin
    sel_ch = base_ptr;
    cand   = base_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = base_ptr + 2'(k);
      if (out_ready[cand]) begin
        sel_ch = cand;
      end
    end
  end
`else
  assign sel_ch = base_ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      dst_q   <= 2'd0;
      data_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      dst_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      if (take) begin
        ptr_q <= dst_q + 2'd1;
      end
      if (accept) begin
        state_q <= StHold;
        data_q  <= in_data;
        dst_q   <= sel_ch;
      end else if (take) begin
        state_q <= StIdle;
      end
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    if (hold) begin
      out_valid[dst_q] = 1'b1;
    end
  end

  assign out_data = data_q;
  assign dst      = dst_q;

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Bench for demux_rr_dispatch: directed scenarios plus random traffic against a
// transaction-level model (held-beat queue and a modulo-4 rotation pointer).
module tb_demux_rr_dispatch;

  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    out_ready;
  logic [1:0]    dst;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            ch;
  } beat_t;

  beat_t held[$];
  int    mptr;

  demux_rr_dispatch #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .dst       (dst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel chosen for a new beat given the rotation pointer and ready vector.
  function automatic int pick(int p, logic [3:0] rdy);
`ifdef DEMUX_SKIP_BUSY_EN
    for (int k = 0; k < 4; k++) begin
      if (rdy[(p + k) % 4]) return (p + k) % 4;
    end
`endif
    return p;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 4'b0000;
    #3;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_valid got=%b exp=0000", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", out_data); end
    checks++; if (dst !== 2'd0) begin errors++; $display("FAIL rst_dst got=%0d exp=0", dst); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_first_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_rotation();
    logic [DW-1:0] d;
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 8'hA0 + 8'(i);
      in_data = d;
      tick();
      checks++; if (out_valid !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rot_valid beat=%0d got=%b exp=%b", i, out_valid, 4'(1 << (i % 4))); end
      checks++; if (out_data !== d) begin errors++; $display("FAIL rot_data beat=%0d got=%h exp=%h", i, out_data, d); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rot_ready beat=%0d got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rot_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_stall();
    // Pointer is 0: one beat to channel 0 moves it to 1.
    in_valid = 1'b1; in_data = 8'h11; out_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 4'b0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h77; out_ready = 4'b1101;
      #1;
      checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL stall_valid cyc=%0d got=%b exp=0010", i, out_valid); end
      checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL stall_data cyc=%0d got=%h exp=5a", i, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (dst !== 2'd1) begin errors++; $display("FAIL stall_dst cyc=%0d got=%0d exp=1", i, dst); end
      tick();
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL stall_done got=%b exp=0000", out_valid); end
    in_valid = 1'b1; in_data = 8'h33; out_ready = 4'b0000;
    tick();
    checks++; if (dst !== 2'd2) begin errors++; $display("FAIL stall_next_dst got=%0d exp=2", dst); end
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_flush();
    // Pointer is 3 here.
    in_valid = 1'b1; in_data = 8'h44; out_ready = 4'b0000;
    tick();
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL flush_pre got=%b exp=1000", out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 4'b1111;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL flush_valid got=%b exp=0000", out_valid); end
    in_valid = 1'b1; in_data = 8'h55; out_ready = 4'b0000;
    tick();
    checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL flush_next got=%b exp=0001", out_valid); end
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL flush_next_data got=%h exp=55", out_data); end
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_async_reset();
    // Pointer is 1 here.
    in_valid = 1'b1; in_data = 8'h66; out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL areset_pre got=%b exp=0010", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL areset_valid got=%b exp=0000", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_ready got=%b exp=0", in_ready); end
    out_ready = 4'b1111;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL areset_lost got=%b exp=0000", out_valid); end
    in_valid = 1'b1; in_data = 8'h88; out_ready = 4'b0000;
    tick();
    checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL areset_first got=%b exp=0001", out_valid); end
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_skip_busy();
    // Pointer is 1 here.
    in_valid = 1'b1; in_data = 8'hC3; out_ready = 4'b1001;
    tick();
    in_valid = 1'b0;
`ifdef DEMUX_SKIP_BUSY_EN
    checks++; if (dst !== 2'd3) begin errors++; $display("FAIL skip_dst got=%0d exp=3", dst); end
    checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL skip_valid got=%b exp=1000", out_valid); end
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL skip_taken got=%b exp=0000", out_valid); end
    in_valid = 1'b1; in_data = 8'h21; out_ready = 4'b0000;
    tick();
    checks++; if (dst !== 2'd0) begin errors++; $display("FAIL skip_ptr got=%0d exp=0", dst); end
`else
    checks++; if (dst !== 2'd1) begin errors++; $display("FAIL skip_dst got=%0d exp=1", dst); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skip_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL skip_wait got=%b exp=0010", out_valid); end
    out_ready = 4'b1111;
    tick();
    in_valid = 1'b1; in_data = 8'h21; out_ready = 4'b0000;
    tick();
    checks++; if (dst !== 2'd2) begin errors++; $display("FAIL skip_ptr got=%0d exp=2", dst); end
`endif
    in_valid = 1'b0; out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_random();
    logic          iv;
    logic          fl;
    logic [DW-1:0] d;
    logic [3:0]    rdy;
    logic          exp_rdy;
    logic [3:0]    exp_v;
    bit            taken;
    beat_t         b;
    // Flush to bring DUT and model into a known common state.
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
    held.delete();
    mptr = 0;
    for (int c = 0; c < 400; c++) begin
      iv  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      d   = DW'($urandom);
      rdy = 4'($urandom);
      in_valid = iv; in_data = d; out_ready = rdy; flush = fl;
      #1;
      exp_v   = 4'b0000;
      exp_rdy = !fl;
      if (held.size() != 0) begin
        exp_v = 4'(1 << held[0].ch);
        if (!rdy[held[0].ch]) exp_rdy = 1'b0;
      end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_v); end
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      if (held.size() != 0) begin
        checks++; if (out_data !== held[0].data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data, held[0].data); end
        checks++; if (dst !== 2'(held[0].ch)) begin errors++; $display("FAIL rnd_dst cyc=%0d got=%0d exp=%0d", c, dst, held[0].ch); end
      end
      if (fl) begin
        held.delete();
        mptr = 0;
      end else begin
        taken = (held.size() != 0) && rdy[held[0].ch];
        if (taken) begin
          mptr = (held[0].ch + 1) % 4;
          void'(held.pop_front());
        end
        if (iv && exp_rdy) begin
          b.data = d;
          b.ch   = pick(mptr, rdy);
          held.push_back(b);
        end
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stall();
    test_flush();
    test_async_reset();
    test_skip_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
